// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// State encodings, default operand width and counter width helper.
package mult_pkg;

    localparam int WIDTH_DEF = 4;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    localparam int CNT_W = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/ripple_adder_n.sv
// Combinational WIDTH-bit ripple-carry adder.
// Built from a chain of full-adder cells.
module ripple_adder_n
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[WIDTH];

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer for an unsigned shift-and-add multiplier.
// One shared ripple adder, WIDTH iterations, registered product.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = cnt_width(WIDTH);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             carry;

    assign addend = a & {WIDTH{q[0]}};
    assign busy   = (state != S_IDLE);

    ripple_adder_n #(.WIDTH(WIDTH)) u_add (
        .a    (acc),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (carry)
    );

    // FSM, iteration counter and the ACC/Q/A shift registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            a     <= '0;
            q     <= '0;
            acc   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a     <= multiplicand;
                        q     <= multiplier;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc <= {carry, sum[WIDTH-1:1]};
                    q   <= {sum[0], q[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Product is published whole on the DONE edge with a one-cycle done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= (state == S_DONE);
            if (state == S_DONE) begin
                product <= {acc, q};
            end
        end
    end

endmodule
